ttt_game_ctrl: RTL and testbench

- Sequential tic-tac-toe game controller; the board-writing end of the game interface.
- Accepts move requests from the player-input logic and keeps the X and O occupancy boards.
- Alternates turns and rejects illegal moves.
- Evaluates the 8 winning lines after every accepted move, then reports win or draw to the display/scoring logic.

---
 rtl/ttt_game_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - sequential tic-tac-toe game controller
//
// Purpose: accepts move requests, keeps the X and O occupancy boards,
// alternates turns, rejects illegal moves and reports win/draw.
// Optional feature macro: MOVE_TIMEOUT_EN (per-turn move timeout, adds the
// timeout output port and a WAIT-state cycle counter).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   new_game   in   clear the board and restart
//   move_valid in   move request strobe
//   move_pos   in   [3:0] cell index 0..8 (row = i/3, column = i%3)
//   move_ready out  high while a request will be sampled (state WAIT)
//   move_ack   out  pulse: previous request accepted
//   move_err   out  pulse: previous request rejected
//   turn       out  player to move (0 = X, 1 = O)
//   board_x    out  [8:0] cells held by X
//   board_o    out  [8:0] cells held by O
//   game_over  out  high while in DONE
//   winner     out  [1:0] 00 none, 01 X, 10 O, 11 draw
//   timeout    out  move timeout expired (MOVE_TIMEOUT_EN only)
module ttt_game_ctrl #(
  parameter logic FIRST_PLAYER   = 1'b0,
  parameter int   TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_ack,
  output logic       move_err,
  output logic       turn,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       game_over,
`ifdef MOVE_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic [1:0] winner
);

  typedef enum logic [1:0] {WAIT, CHECK, DONE} state_t;

  state_t     state, state_d;
  logic [8:0] board_x_d, board_o_d;
  logic       turn_d, move_ack_d, move_err_d, game_over_d;
  logic [1:0] winner_d;
  logic [15:0] occupied;
  logic [15:0] pos_onehot;
  logic       illegal;
  logic [8:0] mover_board;

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt, cnt_d;
  logic          timeout_d;
`endif

  function automatic logic has_line(input logic [8:0] b);
    return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign move_ready = (state == WAIT);

  // Widened to 16 bits so any 4-bit index stays in range; indices 9..15
  // read as unoccupied and are rejected by the range test instead.
  assign occupied    = {7'd0, board_x | board_o};
  assign pos_onehot  = 16'd1 << move_pos;
  assign illegal     = (move_pos > 4'd8) || occupied[move_pos];
  // In CHECK, turn still names the player who just moved.
  assign mover_board = turn ? board_o : board_x;

  always_comb begin
    state_d     = state;
    board_x_d   = board_x;
    board_o_d   = board_o;
    turn_d      = turn;
    winner_d    = winner;
    game_over_d = game_over;
    move_ack_d  = 1'b0;
    move_err_d  = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    cnt_d       = cnt;
    timeout_d   = timeout;
`endif
    if (new_game) begin
      state_d     = WAIT;
      board_x_d   = '0;
      board_o_d   = '0;
      turn_d      = FIRST_PLAYER;
      winner_d    = 2'b00;
      game_over_d = 1'b0;
`ifdef MOVE_TIMEOUT_EN
      cnt_d       = '0;
      timeout_d   = 1'b0;
`endif
    end else begin
      case (state)
        WAIT: begin
          if (move_valid) begin
            if (illegal) begin
              move_err_d = 1'b1;
`ifdef MOVE_TIMEOUT_EN
              cnt_d      = '0;
`endif
            end else begin
              if (turn) board_o_d = board_o | pos_onehot[8:0];
              else      board_x_d = board_x | pos_onehot[8:0];
              move_ack_d = 1'b1;
              state_d    = CHECK;
            end
          end
`ifdef MOVE_TIMEOUT_EN
          else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Player to move forfeits; the opponent wins.
            state_d     = DONE;
            game_over_d = 1'b1;
            timeout_d   = 1'b1;
            winner_d    = turn ? 2'b01 : 2'b10;
          end else begin
            cnt_d = cnt + TW'(1);
          end
`endif
        end
        CHECK: begin
          if (has_line(mover_board)) begin
            state_d     = DONE;
            game_over_d = 1'b1;
            winner_d    = turn ? 2'b10 : 2'b01;
          end else if ((board_x | board_o) == 9'h1FF) begin
            state_d     = DONE;
            game_over_d = 1'b1;
            winner_d    = 2'b11;
          end else begin
            state_d = WAIT;
            turn_d  = ~turn;
`ifdef MOVE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        default: ;  // DONE holds until new_game or rst
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT;
      board_x   <= '0;
      board_o   <= '0;
      turn      <= FIRST_PLAYER;
      winner    <= 2'b00;
      game_over <= 1'b0;
      move_ack  <= 1'b0;
      move_err  <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      cnt       <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      board_x   <= board_x_d;
      board_o   <= board_o_d;
      turn      <= turn_d;
      winner    <= winner_d;
      game_over <= game_over_d;
      move_ack  <= move_ack_d;
      move_err  <= move_err_d;
`ifdef MOVE_TIMEOUT_EN
      cnt       <= cnt_d;
      timeout   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - directed self-checking bench for ttt_game_ctrl
module tb_ttt_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic       move_ready, move_ack, move_err, turn, game_over;
  logic [8:0] board_x, board_o;
  logic [1:0] winner;

  int passed = 0;
  int total  = 0;

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .move_ack   (move_ack),
    .move_err   (move_err),
    .turn       (turn),
    .board_x    (board_x),
    .board_o    (board_o),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Legal move: ack at T+1 (state CHECK), then one more cycle for evaluation.
  task automatic do_move(input logic [3:0] pos, input string tag);
    move_valid = 1'b1;
    move_pos   = pos;
    step();
    move_valid = 1'b0;
    chk({tag, "_ack"},   9'(move_ack),   9'd1);
    chk({tag, "_err"},   9'(move_err),   9'd0);
    chk({tag, "_ready"}, 9'(move_ready), 9'd0);
    step();
  endtask

  task automatic bad_move(input logic [3:0] pos, input string tag);
    move_valid = 1'b1;
    move_pos   = pos;
    step();
    move_valid = 1'b0;
    chk({tag, "_err"},   9'(move_err),   9'd1);
    chk({tag, "_ack"},   9'(move_ack),   9'd0);
    chk({tag, "_ready"}, 9'(move_ready), 9'd1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_bx"},    board_x,          9'h000);
    chk({tag, "_bo"},    board_o,          9'h000);
    chk({tag, "_turn"},  9'(turn),         9'd0);
    chk({tag, "_ack"},   9'(move_ack),     9'd0);
    chk({tag, "_err"},   9'(move_err),     9'd0);
    chk({tag, "_over"},  9'(game_over),    9'd0);
    chk({tag, "_win"},   9'(winner),       9'd0);
    chk({tag, "_ready"}, 9'(move_ready),   9'd1);
  endtask

  task automatic new_game_with_move(input string tag);
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_pos   = 4'd5;
    step();
    new_game   = 1'b0;
    move_valid = 1'b0;
    check_cleared(tag);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_cleared("reset");

    // X wins on the top row
    do_move(4'd0, "xw_m0");
    chk("xw_turn1", 9'(turn), 9'd1);
    do_move(4'd3, "xw_m1");
    chk("xw_turn2", 9'(turn), 9'd0);
    do_move(4'd1, "xw_m2");
    do_move(4'd4, "xw_m3");
    do_move(4'd2, "xw_m4");
    chk("xw_bx",    board_x,         9'h007);
    chk("xw_bo",    board_o,         9'h018);
    chk("xw_win",   9'(winner),      9'd1);
    chk("xw_over",  9'(game_over),   9'd1);
    chk("xw_ready", 9'(move_ready),  9'd0);

    // move in DONE is ignored
    move_valid = 1'b1;
    move_pos   = 4'd5;
    step();
    move_valid = 1'b0;
    chk("done_ack", 9'(move_ack), 9'd0);
    chk("done_err", 9'(move_err), 9'd0);
    chk("done_bo",  board_o,      9'h018);

    // new_game + move_valid in DONE
    new_game_with_move("ng_done");

    // occupied cell
    do_move(4'd4, "occ_x4");
    bad_move(4'd4, "occ_o4");
    chk("occ_bo",   board_o,  9'h000);
    chk("occ_turn", 9'(turn), 9'd1);
    do_move(4'd0, "occ_o0");
    chk("occ_bo2",  board_o,  9'h001);
    chk("occ_bx2",  board_x,  9'h010);

    // out-of-range indices
    bad_move(4'd9, "oor9");
    chk("oor9_bx", board_x, 9'h010);
    chk("oor9_bo", board_o, 9'h001);
    step();
    bad_move(4'd15, "oor15");
    chk("oor15_bx",   board_x,  9'h010);
    chk("oor15_bo",   board_o,  9'h001);
    chk("oor15_turn", 9'(turn), 9'd0);

    // third move, then new_game + move_valid in WAIT
    do_move(4'd8, "ng_m3");
    new_game_with_move("ng_wait");

    // new_game + move_valid during CHECK
    move_valid = 1'b1;
    move_pos   = 4'd2;
    step();
    chk("ngc_ack", 9'(move_ack), 9'd1);
    new_game_with_move("ng_check");

    // O wins on the middle row
    do_move(4'd0, "ow_m0");
    do_move(4'd3, "ow_m1");
    do_move(4'd1, "ow_m2");
    do_move(4'd4, "ow_m3");
    do_move(4'd8, "ow_m4");
    do_move(4'd5, "ow_m5");
    chk("ow_bx",   board_x,        9'h103);
    chk("ow_bo",   board_o,        9'h038);
    chk("ow_win",  9'(winner),     9'd2);
    chk("ow_over", 9'(game_over),  9'd1);
    chk("ow_turn", 9'(turn),       9'd1);

    // draw
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    do_move(4'd0, "dr_m0");
    do_move(4'd1, "dr_m1");
    do_move(4'd2, "dr_m2");
    do_move(4'd4, "dr_m3");
    do_move(4'd3, "dr_m4");
    do_move(4'd5, "dr_m5");
    do_move(4'd7, "dr_m6");
    do_move(4'd6, "dr_m7");
    chk("dr_over7", 9'(game_over), 9'd0);
    do_move(4'd8, "dr_m8");
    chk("dr_bx",   board_x,       9'h18D);
    chk("dr_bo",   board_o,       9'h072);
    chk("dr_win",  9'(winner),    9'd3);
    chk("dr_over", 9'(game_over), 9'd1);
    for (int p = 0; p < 9; p++) begin
      move_valid = 1'b1;
      move_pos   = 4'(p);
      step();
      chk("dr_late_ack", 9'(move_ack), 9'd0);
      chk("dr_late_err", 9'(move_err), 9'd0);
    end
    move_valid = 1'b0;
    chk("dr_hold_bx",  board_x,    9'h18D);
    chk("dr_hold_win", 9'(winner), 9'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
